// File: rtl/uart_time_loader_if.sv
// UART byte handshake plus time-load outputs of the world-clock time loader.
// The host/bench side uses master; the loader itself uses slave.
interface uart_time_loader_if;
  logic [7:0] rxdata;
  logic       rxready;
  logic       rxclk;
  logic [7:0] txdata;
  logic       txready;
  logic       txclk;
  logic       load;
  logic [6:0] load_hours;
  logic [6:0] load_minutes;
  logic [6:0] load_seconds;
  logic       frame_error;

  modport master (
    output rxdata, rxready, txready,
    input  rxclk, txdata, txclk, load, load_hours, load_minutes, load_seconds, frame_error
  );

  modport slave (
    input  rxdata, rxready, txready,
    output rxclk, txdata, txclk, load, load_hours, load_minutes, load_seconds, frame_error
  );
endinterface

// File: rtl/uart_time_loader.sv
// Parses "T HHMMSS <CR|LF>" frames from the UART, presets the clock24 counters
// with a one-cycle load strobe and answers each finished frame with 'K' or 'E'.
module uart_time_loader #(
  parameter int TIMEOUT_CYCLES = 500
) (
  input logic               clk,
  input logic               reset,
  uart_time_loader_if.slave bus
);

  localparam int              TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]      CH_T     = 8'h54;
  localparam logic [7:0]      CH_CR    = 8'h0D;
  localparam logic [7:0]      CH_LF    = 8'h0A;
  localparam logic [7:0]      CH_K     = 8'h4B;
  localparam logic [7:0]      CH_E     = 8'h45;

  typedef enum logic [1:0] {IDLE, DIGITS, TERM, RESPOND} state_t;

  state_t          state_q, state_d;
  logic            rx_q;
  logic            accept;
  logic [2:0]      idx_q, idx_d;
  logic [5:0][3:0] digits_q, digits_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic            rxclk_q;
  logic            txclk_q, txclk_d;
  logic            load_q, load_d;
  logic            ferr_q, ferr_d;
  logic [7:0]      txdata_q, txdata_d;
  logic [6:0]      hours_q, hours_d;
  logic [6:0]      minutes_q, minutes_d;
  logic [6:0]      seconds_q, seconds_d;
  logic [6:0]      hours_v, minutes_v, seconds_v;
  logic            is_digit, is_term, time_ok, timed_out;

  function automatic logic [6:0] field(input logic [3:0] tens, input logic [3:0] ones);
    return 7'(tens) * 7'd10 + 7'(ones);
  endfunction

  assign accept    = bus.rxready & ~rx_q;
  assign is_digit  = (bus.rxdata >= 8'h30) && (bus.rxdata <= 8'h39);
  assign is_term   = (bus.rxdata == CH_CR) || (bus.rxdata == CH_LF);
  assign hours_v   = field(digits_q[0], digits_q[1]);
  assign minutes_v = field(digits_q[2], digits_q[3]);
  assign seconds_v = field(digits_q[4], digits_q[5]);
  assign time_ok   = (hours_v <= 7'd23) && (minutes_v <= 7'd59) && (seconds_v <= 7'd59);
  assign timed_out = (tmo_q == TMO_LAST);

  always_comb begin
    // NOTE: every target gets its default first, so no path through the case can infer a latch.
    state_d   = state_q;
    idx_d     = idx_q;
    digits_d  = digits_q;
    txdata_d  = txdata_q;
    hours_d   = hours_q;
    minutes_d = minutes_q;
    seconds_d = seconds_q;
    load_d    = 1'b0;
    txclk_d   = 1'b0;
    ferr_d    = 1'b0;
    tmo_d     = '0;
    if ((state_q == DIGITS || state_q == TERM) && !accept) tmo_d = tmo_q + TW'(1);

    unique case (state_q)
      IDLE: begin
        if (accept && bus.rxdata == CH_T) begin
          state_d  = DIGITS;
          idx_d    = '0;
          digits_d = '0;
        end
      end
      DIGITS: begin
        if (accept) begin
          if (bus.rxdata == CH_T) begin
            idx_d    = '0;
            digits_d = '0;
          end else if (is_digit) begin
            digits_d[idx_q] = bus.rxdata[3:0];
            idx_d           = idx_q + 3'd1;
            if (idx_q == 3'd5) state_d = TERM;
          end else begin
            state_d  = RESPOND;
            txdata_d = CH_E;
            ferr_d   = 1'b1;
          end
        end else if (timed_out) begin
          state_d = IDLE;
          ferr_d  = 1'b1;
          tmo_d   = '0;
        end
      end
      TERM: begin
        if (accept) begin
          if (bus.rxdata == CH_T) begin
            state_d  = DIGITS;
            idx_d    = '0;
            digits_d = '0;
          end else if (is_term && time_ok) begin
            state_d   = RESPOND;
            txdata_d  = CH_K;
            load_d    = 1'b1;
            hours_d   = hours_v;
            minutes_d = minutes_v;
            seconds_d = seconds_v;
          end else begin
            state_d  = RESPOND;
            txdata_d = CH_E;
            ferr_d   = 1'b1;
          end
        end else if (timed_out) begin
          state_d = IDLE;
          ferr_d  = 1'b1;
          tmo_d   = '0;
        end
      end
      RESPOND: begin
        // Bytes arriving here are dropped; only txready moves us on.
        if (bus.txready) begin
          txclk_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      rx_q      <= 1'b0;
      idx_q     <= '0;
      digits_q  <= '0;
      tmo_q     <= '0;
      rxclk_q   <= 1'b0;
      txclk_q   <= 1'b0;
      load_q    <= 1'b0;
      ferr_q    <= 1'b0;
      txdata_q  <= 8'h00;
      hours_q   <= '0;
      minutes_q <= '0;
      seconds_q <= '0;
    end else begin
      state_q   <= state_d;
      rx_q      <= bus.rxready;
      idx_q     <= idx_d;
      digits_q  <= digits_d;
      tmo_q     <= tmo_d;
      rxclk_q   <= accept;
      txclk_q   <= txclk_d;
      load_q    <= load_d;
      ferr_q    <= ferr_d;
      txdata_q  <= txdata_d;
      hours_q   <= hours_d;
      minutes_q <= minutes_d;
      seconds_q <= seconds_d;
    end
  end

  assign bus.rxclk        = rxclk_q;
  assign bus.txclk        = txclk_q;
  assign bus.txdata       = txdata_q;
  assign bus.load         = load_q;
  assign bus.load_hours   = hours_q;
  assign bus.load_minutes = minutes_q;
  assign bus.load_seconds = seconds_q;
  assign bus.frame_error  = ferr_q;

endmodule

// File: tb/tb_uart_time_loader.sv
// Scoreboard bench for uart_time_loader: a byte-level frame model predicts load,
// frame_error and txclk strobes (with their cycle); a negedge monitor compares.
module tb_uart_time_loader;
  localparam int TMO = 500;

  logic   clk = 1'b0;
  logic   reset;
  longint cyc = 0;

  uart_time_loader_if bus();
  uart_time_loader #(.TIMEOUT_CYCLES(TMO)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef enum int {EV_LOAD, EV_FERR, EV_TX} ev_kind_t;
  typedef struct {
    ev_kind_t kind;
    int       h, m, s, tx;
    longint   cyc;
  } ev_t;

  ev_t sb[$];
  int  checks = 0, errors = 0;
  int  rx_count = 0, bytes_sent = 0;
  bit  m_active = 0;
  int  m_buf[$];
  int  held_h = 0, held_m = 0, held_s = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void expect_ev(ev_kind_t k, int h, int m, int s, int tx, longint c);
    ev_t e;
    e.kind = k; e.h = h; e.m = m; e.s = s; e.tx = tx; e.cyc = c;
    sb.push_back(e);
  endfunction

  // Frame model: returns the response byte due after this byte, or 0.
  function automatic int model_byte(input int b, input longint a);
    int h, m, s;
    if (!m_active) begin
      if (b == "T") begin m_active = 1; m_buf.delete(); end
      return 0;
    end
    if (b == "T") begin m_buf.delete(); return 0; end
    if (m_buf.size() < 6 && b >= "0" && b <= "9") begin
      m_buf.push_back(b - "0");
      return 0;
    end
    m_active = 0;
    if (m_buf.size() == 6 && (b == 13 || b == 10)) begin
      h = m_buf[0] * 10 + m_buf[1];
      m = m_buf[2] * 10 + m_buf[3];
      s = m_buf[4] * 10 + m_buf[5];
      if (h <= 23 && m <= 59 && s <= 59) begin
        expect_ev(EV_LOAD, h, m, s, 0, a);
        held_h = h; held_m = m; held_s = s;
        return "K";
      end
    end
    expect_ev(EV_FERR, 0, 0, 0, 0, a);
    return "E";
  endfunction

  always @(negedge clk) begin
    int   n, kind;
    ev_t  e;
    if (!reset) begin
      if (bus.rxclk) rx_count++;
      n = int'(bus.load) + int'(bus.frame_error) + int'(bus.txclk);
      if (n > 1) check("single strobe per cycle", n, 1);
      else if (n == 1) begin
        kind = bus.load ? EV_LOAD : (bus.frame_error ? EV_FERR : EV_TX);
        if (sb.size() == 0) check("unexpected strobe kind", kind, -1);
        else begin
          e = sb.pop_front();
          check("strobe kind", kind, e.kind);
          check("strobe cycle", cyc, e.cyc);
          if (e.kind == EV_LOAD) begin
            check("load_hours", bus.load_hours, e.h);
            check("load_minutes", bus.load_minutes, e.m);
            check("load_seconds", bus.load_seconds, e.s);
          end
          if (e.kind == EV_TX) check("txdata", bus.txdata, e.tx);
        end
      end
    end
  end

  // One byte, next byte starts gap cycles later; hold>0 keeps txready low that long.
  task automatic send(input int b, input int gap, input int hold);
    longint a;
    int     r;
    a = cyc + 1;
    r = model_byte(b, a);
    if (m_active && gap > TMO) begin
      expect_ev(EV_FERR, 0, 0, 0, 0, a + TMO);
      m_active = 0;
    end
    bus.rxdata  = 8'(b);
    bus.rxready = 1'b1;
    if (r != 0) begin
      if (hold == 0) expect_ev(EV_TX, 0, 0, 0, r, a + 1);
      else bus.txready = 1'b0;
    end
    bytes_sent++;
    @(negedge clk);
    bus.rxready = 1'b0;
    repeat (gap - 1) @(negedge clk);
    if (r != 0 && hold > 0) begin
      // A byte landing while the response waits must be ignored.
      case ($urandom_range(0, 2))
        0:       bus.rxdata = "T";
        1:       bus.rxdata = "5";
        default: bus.rxdata = 8'h0D;
      endcase
      bus.rxready = 1'b1;
      bytes_sent++;
      @(negedge clk);
      bus.rxready = 1'b0;
      @(negedge clk);
      repeat (hold) @(negedge clk);
      expect_ev(EV_TX, 0, 0, 0, r, cyc + 1);
      bus.txready = 1'b1;
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic send_str(input string str, input int gap, input int hold);
    for (int i = 0; i < str.len(); i++) send(str[i], gap, hold);
  endtask

  task automatic checkpoint(input string tag);
    repeat (3) @(negedge clk);
    check({tag, " rxclk count"}, rx_count, bytes_sent);
    check({tag, " pending strobes"}, sb.size(), 0);
    check({tag, " held hours"}, bus.load_hours, held_h);
    check({tag, " held minutes"}, bus.load_minutes, held_m);
    check({tag, " held seconds"}, bus.load_seconds, held_s);
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    bus.rxready = 1'b0;
    bus.txready = 1'b1;
    repeat (2) @(negedge clk);
    check("reset load", bus.load, 0);
    check("reset txclk", bus.txclk, 0);
    check("reset rxclk", bus.rxclk, 0);
    check("reset frame_error", bus.frame_error, 0);
    check("reset txdata", bus.txdata, 0);
    check("reset hours", bus.load_hours, 0);
    check("reset minutes", bus.load_minutes, 0);
    check("reset seconds", bus.load_seconds, 0);
    m_active = 0;
    held_h = 0; held_m = 0; held_s = 0;
    sb.delete();
    rx_count = 0;
    bytes_sent = 0;
    reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int    kind, gap, hold, h, m, s, k;
    string f, term;
    reset       = 1'b1;
    bus.rxdata  = 8'h00;
    bus.rxready = 1'b0;
    bus.txready = 1'b1;
    @(negedge clk);
    do_reset();

    send_str("T123456\r", 3, 0);
    checkpoint("basic");
    send_str("T245900\n", 2, 0);
    checkpoint("bad hours");
    send_str("T12A", 3, 0);
    send_str("T000000\r", 2, 0);
    checkpoint("bad char");
    send_str("T123", 3, 0);
    send("4", TMO + 1, 0);
    send_str("T235959\r", 2, 0);
    checkpoint("timeout");
    send_str("T12345", 2, 0);
    send("6", TMO, 0);
    send("\n", 2, 0);
    checkpoint("gap at limit");
    send_str("xyT12T010203\r", 2, 18);
    checkpoint("restart and txready hold");
    send_str("T1234", 3, 0);
    do_reset();
    send_str("56\r", 3, 0);
    checkpoint("reset mid frame");

    for (int it = 0; it < 30; it++) begin
      kind = $urandom_range(0, 5);
      gap  = $urandom_range(2, 5);
      hold = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 10) : 0;
      h    = $urandom_range(0, 23);
      m    = $urandom_range(0, 59);
      s    = $urandom_range(0, 59);
      term = ($urandom_range(0, 1) == 1) ? "\r" : "\n";
      if (kind == 1) begin
        case ($urandom_range(0, 2))
          0:       h = $urandom_range(24, 99);
          1:       m = $urandom_range(60, 99);
          default: s = $urandom_range(60, 99);
        endcase
      end
      f = $sformatf("T%02d%02d%02d%s", h, m, s, term);
      case (kind)
        2: f.putc($urandom_range(1, 7), "A");
        3: f = {$sformatf("qT%0d", h), f};
        5: f = $sformatf("T%02d%02d%02d%0d", h, m, s, $urandom_range(0, 9));
        default: ;
      endcase
      if (kind == 4 && (it % 7) == 3) begin
        k = $urandom_range(0, 6);
        for (int i = 0; i < k; i++) send(f[i], gap, 0);
        send(f[k], TMO + 1, 0);
      end else begin
        send_str(f, gap, hold);
      end
    end
    checkpoint("random");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
